bt_frame_packer: RTL and testbench

- Parametrised successor of the sensor-to-PC streaming path.
- Captures NUM_CH sensor channels (accelerometer/magnetometer class) as one snapshot and packs it into a framed 32-bit word stream: header word, then one word per channel.
- Buffers frames in an internal single-clock FIFO and presents a block-throttled read interface for a block-throttled pipe-out endpoint.
- Never splits a frame, counts dropped frames and flags underflow.

---
 rtl/bt_frame_packer.sv | 157 +++++++++++++++
 tb/tb_bt_frame_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_frame_packer.sv
// Sensor snapshot framer: packs NUM_CH samples into {header, channel words} and buffers them in a FIFO for a block-throttled pipe reader.
// Optional: define BT_FRAME_PACKER_CHECKSUM_EN to append an XOR checksum word to every frame.
module bt_frame_packer #(
  parameter int          NUM_CH      = 6,
  parameter int          DATA_W      = 16,
  parameter int          DEPTH       = 1024,
  parameter int          BLOCK_WORDS = 256,
  parameter logic [15:0] SYNC_WORD   = 16'hA55A
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH*DATA_W-1:0]   sample_data,
  input  logic                       sample_valid,
  input  logic                       ep_read,
  input  logic                       ep_blockstrobe,
  output logic [31:0]                ep_dataout,
  output logic                       ep_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                frames_dropped,
  output logic                       underflow,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef BT_FRAME_PACKER_CHECKSUM_EN
  localparam int FRAME_WORDS = NUM_CH + 2;
  typedef enum logic [1:0] {IDLE, HDR, CH, SUM} state_t;
`else
  localparam int FRAME_WORDS = NUM_CH + 1;
  typedef enum logic [1:0] {IDLE, HDR, CH} state_t;
`endif

  state_t             state, state_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [15:0]        frame_cnt;
  logic [DATA_W-1:0]  shadow [NUM_CH];
  logic [31:0]        mem [DEPTH];
  logic [LW-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LW-1:0]      free_words, level_nxt, part_cnt, part_nxt;
  logic [31:0]        wr_word, hdr_word, ch_word;
  logic               wr_en, rd_en, accept, frame_done, ready_nxt;
  logic               unused_blockstrobe;
`ifdef BT_FRAME_PACKER_CHECKSUM_EN
  logic [31:0]        chk;
`endif

  assign unused_blockstrobe = ep_blockstrobe;

  assign hdr_word   = {SYNC_WORD, frame_cnt};
  assign ch_word    = 32'(signed'(shadow[idx]));
  assign free_words = LW'(DEPTH) - fifo_level;
  assign busy       = (state != IDLE);

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    wr_en      = 1'b0;
    wr_word    = '0;
    accept     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid && free_words >= LW'(FRAME_WORDS)) begin
          accept    = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        wr_en     = 1'b1;
        wr_word   = hdr_word;
        idx_nxt   = '0;
        state_nxt = CH;
      end
      CH: begin
        wr_en   = 1'b1;
        wr_word = ch_word;
        if (idx == IW'(NUM_CH - 1)) begin
`ifdef BT_FRAME_PACKER_CHECKSUM_EN
          state_nxt = SUM;
`else
          state_nxt  = IDLE;
          frame_done = 1'b1;
`endif
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
`ifdef BT_FRAME_PACKER_CHECKSUM_EN
      SUM: begin
        wr_en      = 1'b1;
        wr_word    = chk;
        state_nxt  = IDLE;
        frame_done = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en      = ep_read && (fifo_level != '0);
  assign wr_ptr_nxt = wr_ptr + LW'(wr_en);
  assign rd_ptr_nxt = rd_ptr + LW'(rd_en);
  assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  // ep_ready counts only completed frames, so a reader draining a block never stops inside a frame.
  assign part_nxt   = (state_nxt == IDLE) ? '0 : part_cnt + LW'(wr_en);
  assign ready_nxt  = {1'b0, level_nxt} >= ({1'b0, part_nxt} + (LW+1)'(BLOCK_WORDS));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      frame_cnt      <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      part_cnt       <= '0;
      ep_ready       <= 1'b0;
      ep_dataout     <= '0;
      frames_dropped <= '0;
      underflow      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_nxt;
      part_cnt   <= part_nxt;
      ep_ready   <= ready_nxt;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (rd_en) ep_dataout <= mem[rd_ptr[AW-1:0]];
      if (ep_read && fifo_level == '0) underflow <= 1'b1;
      if (sample_valid && !accept && frames_dropped != 16'hFFFF)
        frames_dropped <= frames_dropped + 16'd1;
      if (accept)
        for (int i = 0; i < NUM_CH; i++) shadow[i] <= sample_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef BT_FRAME_PACKER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           chk <= '0;
    else if (state == HDR)  chk <= hdr_word;
    else if (state == CH)   chk <= chk ^ ch_word;
  end
`endif

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

endmodule

// File: tb/tb_bt_frame_packer.sv
// Scoreboard bench for bt_frame_packer: stimulus pushes expected words, a monitor pops and compares on every read.
module tb_bt_frame_packer;

  localparam int NUM_CH = 6;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;
  localparam int BLOCK  = 256;
`ifdef BT_FRAME_PACKER_CHECKSUM_EN
  localparam int FW = NUM_CH + 2;
`else
  localparam int FW = NUM_CH + 1;
`endif

  logic                      clk, reset_n;
  logic [NUM_CH*DATA_W-1:0]  sample_data;
  logic                      sample_valid, ep_read, ep_blockstrobe;
  logic [31:0]               ep_dataout;
  logic                      ep_ready, underflow, busy;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic [15:0]               frames_dropped;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;
  logic [31:0] mon_w;
  int          m_drops = 0;
  logic [15:0] m_cnt = '0;

  bt_frame_packer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
                    .BLOCK_WORDS(BLOCK), .SYNC_WORD(16'hA55A)) dut (
    .clk(clk), .reset_n(reset_n), .sample_data(sample_data),
    .sample_valid(sample_valid), .ep_read(ep_read), .ep_blockstrobe(ep_blockstrobe),
    .ep_dataout(ep_dataout), .ep_ready(ep_ready), .fifo_level(fifo_level),
    .frames_dropped(frames_dropped), .underflow(underflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every read of a non-empty FIFO shows the head word one edge later.
  always @(posedge clk) begin
    if (ep_read && reset_n && exp_q.size() > 0) begin
      mon_w = exp_q.pop_front();
      #1;
      check("rd_data", ep_dataout, mon_w);
      last_exp = mon_w;
    end
  end

  function automatic logic [31:0] sext16(input logic [15:0] s);
    return {{16{s[15]}}, s};
  endfunction

  task automatic push_frame(input logic [NUM_CH*DATA_W-1:0] d);
    logic [31:0] w, chk;
    chk = {16'hA55A, m_cnt};
    exp_q.push_back(chk);
    for (int c = 0; c < NUM_CH; c++) begin
      w = sext16(d[c*DATA_W +: DATA_W]);
      exp_q.push_back(w);
      chk = chk ^ w;
    end
`ifdef BT_FRAME_PACKER_CHECKSUM_EN
    exp_q.push_back(chk);
`endif
    m_cnt++;
  endtask

  // Called on a negedge with the packer idle; returns one cycle later.
  task automatic send(input logic [NUM_CH*DATA_W-1:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    if (exp_q.size() + FW <= DEPTH) push_frame(d);
    else m_drops++;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      ep_read = 1'b1;
      @(negedge clk);
    end
    ep_read = 1'b0;
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] pattern(input int f);
    logic [NUM_CH*DATA_W-1:0] d;
    for (int c = 0; c < NUM_CH; c++) d[c*DATA_W +: DATA_W] = 16'(f * 4099 + c * 12289 + 7);
    return d;
  endfunction

  initial begin
    int bc, nf;
    reset_n = 1'b0; sample_data = '0; sample_valid = 1'b0;
    ep_read = 1'b0; ep_blockstrobe = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dataout", ep_dataout, 32'h0);
    check("rst_ready", 32'(ep_ready), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_dropped", 32'(frames_dropped), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // First frame, expected words written out by hand.
    sample_data  = {16'h0005, 16'h0000, 16'h8000, 16'h7FFF, 16'h1234, 16'h8001};
    sample_valid = 1'b1;
    exp_q.push_back(32'hA55A0000); exp_q.push_back(32'hFFFF8001);
    exp_q.push_back(32'h00001234); exp_q.push_back(32'h00007FFF);
    exp_q.push_back(32'hFFFF8000); exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00000005);
`ifdef BT_FRAME_PACKER_CHECKSUM_EN
    exp_q.push_back(32'hA55A6DCF);
`endif
    m_cnt = 16'd1;
    @(negedge clk);
    sample_valid = 1'b0;
    ep_blockstrobe = 1'b1;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      bc++;
      @(negedge clk);
    end
    ep_blockstrobe = 1'b0;
    check("busy_cycles", 32'(bc), 32'(FW));
    check("level_one_frame", 32'(fifo_level), 32'(FW));
    read_n(FW);
    check("level_drained", 32'(fifo_level), 32'd0);

    // Underflow: sticky flag, output word holds.
    read_n(1);
    check("underflow_set", 32'(underflow), 32'd1);
`ifdef BT_FRAME_PACKER_CHECKSUM_EN
    check("underflow_hold", ep_dataout, 32'hA55A6DCF);
`else
    check("underflow_hold", ep_dataout, 32'h00000005);
`endif
    check("underflow_level", 32'(fifo_level), 32'd0);

    // ep_ready must wait for the frame that crosses BLOCK words to complete.
    nf = (BLOCK + FW - 1) / FW;
    for (int f = 0; f < nf - 1; f++) begin
      send(pattern(f));
      wait_idle();
    end
    check("ready_before", 32'(ep_ready), 32'd0);
    check("level_before", 32'(fifo_level), 32'((nf - 1) * FW));
    send(pattern(nf));
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      check("ready_mid_frame", 32'(ep_ready), 32'd0);
      @(negedge clk);
    end
    check("level_block", 32'(fifo_level), 32'(nf * FW));
    check("ready_after", 32'(ep_ready), 32'd1);

    // Nearly full FIFO: frame dropped, then accepted after reads free space.
    for (int f = 0; f < 200 && exp_q.size() + FW <= DEPTH; f++) begin
      send(pattern(100 + f));
      wait_idle();
    end
    read_n(exp_q.size() - 1020);
    check("level_1020", 32'(fifo_level), 32'd1020);
    send(pattern(7));
    repeat (2) @(negedge clk);
    check("drop_full", 32'(frames_dropped), 32'd1);
    check("level_after_drop", 32'(fifo_level), 32'd1020);
    check("busy_after_drop", 32'(busy), 32'd0);
    read_n(10);
    send(pattern(8));
    wait_idle();
    check("level_accepted", 32'(fifo_level), 32'(1010 + FW));
    check("drop_model", 32'(frames_dropped), 32'(m_drops));
    read_n(exp_q.size());
    check("level_empty", 32'(fifo_level), 32'd0);

    // sample_valid while busy: dropped, current frame intact.
    send(pattern(9));
    @(negedge clk);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_drops++;
    wait_idle();
    check("drop_busy", 32'(frames_dropped), 32'd2);
    check("level_busy_frame", 32'(fifo_level), 32'(FW));
    read_n(FW);

    // Reset mid-frame.
    send(pattern(10));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_ready", 32'(ep_ready), 32'd0);
    check("mrst_dataout", ep_dataout, 32'h0);
    check("mrst_dropped", 32'(frames_dropped), 32'd0);
    check("mrst_underflow", 32'(underflow), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    m_cnt = '0;
    m_drops = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(pattern(11));
    wait_idle();
    check("post_rst_level", 32'(fifo_level), 32'(FW));
    read_n(FW);

`ifdef BT_FRAME_PACKER_CHECKSUM_EN
    send('0); wait_idle(); read_n(FW);
    send('0); wait_idle(); read_n(FW);
    sample_data  = '0;
    sample_valid = 1'b1;
    exp_q.push_back(32'hA55A0003);
    for (int c = 0; c < NUM_CH; c++) exp_q.push_back(32'h0);
    exp_q.push_back(32'hA55A0003);
    m_cnt++;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_idle();
    read_n(FW);
`endif
    check("final_level", 32'(fifo_level), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
